// File: rtl/sram_stream_master.sv
// Burst initiator for a single-port SRAM (CEN/WEN/A/D/Q): write bursts sink a stream, read bursts source one.
// Define SRAM_STREAM_PERF_EN to add the stall_cnt output (cycles spent busy with the SRAM idle).
module sram_stream_master #(
  parameter int BW       = 32,
  parameter int AW       = 11,
  parameter int OBUF_DEP = 4
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  input  logic [BW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [BW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          CEN,
  output logic          WEN,
  output logic [AW-1:0] A,
  output logic [BW-1:0] D,
`ifdef SRAM_STREAM_PERF_EN
  output logic [15:0]   stall_cnt,
`endif
  input  logic [BW-1:0] Q
);

  localparam int PW = (OBUF_DEP > 1) ? $clog2(OBUF_DEP) : 1;
  localparam int CW = $clog2(OBUF_DEP + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          cen_q, cen_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] a_q, a_d;
  logic [BW-1:0] d_q, d_d;
  // Read pipeline: address on the SRAM pins this cycle, then Q valid the cycle after.
  logic          rd_lat_q;
  logic          rd_dat_q;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] occ_q;
  logic [BW-1:0] obuf_q [OBUF_DEP];

  logic          wr_hs;
  logic          rd_issue;
  logic          credit_ok;
  logic          obuf_push;
  logic          obuf_pop;
  logic [CW:0]   credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEP - 1)) ? '0 : p + PW'(1);
  endfunction

  assign busy      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign in_ready  = (state_q == ST_WRITE) && (cnt_q < len_q);
  assign wr_hs     = in_ready && in_valid;
  assign out_valid = (occ_q != '0);
  assign out_data  = obuf_q[rd_ptr_q];
  assign obuf_push = rd_dat_q;
  assign obuf_pop  = out_valid && out_ready;

  // Every issued read reserves an OBUF slot until it is popped, whatever out_ready does.
  assign credit_used = {1'b0, occ_q} + (CW+1)'(rd_lat_q) + (CW+1)'(rd_dat_q);
  assign credit_ok   = credit_used < (CW+1)'(OBUF_DEP);
  assign rd_issue    = (state_q == ST_READ) && (cnt_q < len_q) && credit_ok;

  assign CEN = cen_q;
  assign WEN = wen_q;
  assign A   = a_q;
  assign D   = d_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    cen_d   = 1'b1;
    wen_d   = 1'b1;
    a_d     = a_q;
    d_d     = d_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d  = len;
          cnt_d  = '0;
          addr_d = base;
          if (len == '0)  state_d = ST_DONE;
          else if (mode)  state_d = ST_READ;
          else            state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_hs) begin
          cen_d  = 1'b0;
          wen_d  = 1'b0;
          a_d    = addr_q;
          d_d    = in_data;
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q + (AW+1)'(1);
        end
        // Leave only once the final write cycle is on the pins, so DONE never overlaps it.
        if (cnt_q == len_q) state_d = ST_DONE;
      end
      ST_READ: begin
        if (rd_issue) begin
          cen_d  = 1'b0;
          a_d    = addr_q;
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q + (AW+1)'(1);
          if ((cnt_q + (AW+1)'(1)) == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!rd_lat_q && !rd_dat_q && !out_valid) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      cen_q    <= 1'b1;
      wen_q    <= 1'b1;
      a_q      <= '0;
      d_q      <= '0;
      rd_lat_q <= 1'b0;
      rd_dat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      a_q      <= a_d;
      d_q      <= d_d;
      rd_lat_q <= rd_issue;
      rd_dat_q <= rd_lat_q;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < OBUF_DEP; i++) obuf_q[i] <= '0;
    end else begin
      if (obuf_push) begin
        obuf_q[wr_ptr_q] <= Q;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (obuf_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({obuf_push, obuf_pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef SRAM_STREAM_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start)
      stall_d = '0;
    else if (busy && cen_q && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
